// File: rtl/hi_ssp_framer.sv
// hi_ssp_framer
// SSP link engine between the FPGA mode blocks and the ARM. Generates
// ssp_clk and ssp_frame from ck_1356meg and shifts buffered TX words out on
// ssp_din, MSB first. In the same frames it shifts ARM words in from
// ssp_dout.
//
// Ports:
//   ck_1356meg  in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   link enable
//   tx_data     in   [WORD_W] word to send to the ARM
//   tx_valid    in   tx_data offered
//   tx_ready    out  FIFO not full
//   fifo_level  out  current TX FIFO occupancy
//   rx_data     out  [WORD_W] last complete word received from the ARM
//   rx_valid    out  one-cycle pulse, rx_data updated
//   underrun    out  one-cycle pulse, zero word sent because the FIFO was empty
//   ssp_clk     out  SSP clock to the ARM
//   ssp_frame   out  frame marker, high for the first bit period of each word
//   ssp_din     out  serial data to the ARM
//   ssp_dout    in   serial data from the ARM
module hi_ssp_framer #(
   parameter int WORD_W     = 8,
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               ck_1356meg,
   input  logic                               rst_n,
   input  logic                               en,
   input  logic [WORD_W-1:0]                  tx_data,
   input  logic                               tx_valid,
   output logic                               tx_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
   output logic [WORD_W-1:0]                  rx_data,
   output logic                               rx_valid,
   output logic                               underrun,
   output logic                               ssp_clk,
   output logic                               ssp_frame,
   output logic                               ssp_din,
   input  logic                               ssp_dout
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(WORD_W);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   // en_q_r marks that en was already high on the previous edge; the edge on
   // which en is first seen high only arms the divider, so the first rise
   // tick lands CLK_DIV edges later.
   logic                en_q_r;
   logic [DIV_W-1:0]    div_cnt_r;
   logic [BIT_W-1:0]    bit_cnt_r;
   logic                ssp_clk_r;
   logic                ssp_frame_r;
   logic                ssp_din_r;
   logic                underrun_r;
   logic [WORD_W-1:0]   tx_sh_r;

   logic [WORD_W-1:0]   rx_sh_r;
   logic [WORD_W-1:0]   rx_data_r;
   logic                rx_valid_r;
   logic                rx_armed_r;

   logic [WORD_W-1:0]   fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [LVL_W-1:0]    level_r;
   logic                tx_ready_r;

   logic                run_s;
   logic                tick_s;
   logic                rise_tick_s;
   logic                word_start_s;
   logic                push_s;
   logic                pop_s;
   logic [WORD_W-1:0]   head_s;
   logic [LVL_W-1:0]    level_nxt_s;
   logic [WORD_W-1:0]   rx_word_s;

   // Link strobes, FIFO handshake and next occupancy.
   always_comb begin
      run_s        = en & en_q_r;
      tick_s       = run_s & (div_cnt_r == DIV_LAST);
      rise_tick_s  = tick_s & ~ssp_clk_r;
      word_start_s = rise_tick_s & (bit_cnt_r == BIT_LAST);
      push_s       = tx_valid & tx_ready_r;
      pop_s        = word_start_s & (level_r != {LVL_W{1'b0}});
      // An empty FIFO at word start sends an all-zero word.
      if (pop_s) begin
         head_s = fifo_mem_r[rd_ptr_r];
      end else begin
         head_s = {WORD_W{1'b0}};
      end
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_W'(1);
         2'b01:   level_nxt_s = level_r - LVL_W'(1);
         default: level_nxt_s = level_r;
      endcase
      rx_word_s = {rx_sh_r[WORD_W-2:0], ssp_dout};
   end

   // Clock divider and ssp_clk generation; everything idles while en is low.
   always_ff @(posedge ck_1356meg or negedge rst_n) begin
      if (!rst_n) begin
         en_q_r    <= 1'b0;
         div_cnt_r <= {DIV_W{1'b0}};
         ssp_clk_r <= 1'b0;
      end else if (!en) begin
         en_q_r    <= 1'b0;
         div_cnt_r <= {DIV_W{1'b0}};
         ssp_clk_r <= 1'b0;
      end else begin
         en_q_r <= 1'b1;
         if (tick_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            ssp_clk_r <= ~ssp_clk_r;
         end else if (run_s) begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
         end else begin
            div_cnt_r <= div_cnt_r;
         end
      end
   end

   // Bit counter, TX shifter, frame marker and underrun pulse.
   always_ff @(posedge ck_1356meg or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r   <= BIT_LAST;
         tx_sh_r     <= {WORD_W{1'b0}};
         ssp_frame_r <= 1'b0;
         ssp_din_r   <= 1'b0;
         underrun_r  <= 1'b0;
      end else begin
         underrun_r <= 1'b0;
         if (!en) begin
            // A partially sent word is dropped, not re-queued.
            bit_cnt_r   <= BIT_LAST;
            tx_sh_r     <= {WORD_W{1'b0}};
            ssp_frame_r <= 1'b0;
            ssp_din_r   <= 1'b0;
         end else if (rise_tick_s) begin
            if (bit_cnt_r == {BIT_W{1'b0}}) begin
               bit_cnt_r <= BIT_LAST;
            end else begin
               bit_cnt_r <= bit_cnt_r - BIT_W'(1);
            end
            if (word_start_s) begin
               tx_sh_r     <= head_s;
               ssp_din_r   <= head_s[WORD_W-1];
               ssp_frame_r <= 1'b1;
               underrun_r  <= ~pop_s;
            end else begin
               tx_sh_r     <= {tx_sh_r[WORD_W-2:0], 1'b0};
               ssp_din_r   <= tx_sh_r[WORD_W-2];
               ssp_frame_r <= 1'b0;
            end
         end
      end
   end

   // RX shifter. The sample taken at the first word start after enable
   // belongs to no word, so delivery is armed only from that start on.
   always_ff @(posedge ck_1356meg or negedge rst_n) begin
      if (!rst_n) begin
         rx_sh_r    <= {WORD_W{1'b0}};
         rx_data_r  <= {WORD_W{1'b0}};
         rx_valid_r <= 1'b0;
         rx_armed_r <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         if (!en) begin
            rx_sh_r    <= {WORD_W{1'b0}};
            rx_armed_r <= 1'b0;
         end else if (rise_tick_s) begin
            rx_sh_r <= rx_word_s;
            if (word_start_s) begin
               rx_armed_r <= 1'b1;
               if (rx_armed_r) begin
                  rx_data_r  <= rx_word_s;
                  rx_valid_r <= 1'b1;
               end
            end
         end
      end
   end

   // TX FIFO storage, pointers and registered occupancy / ready.
   always_ff @(posedge ck_1356meg or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= {WORD_W{1'b0}};
         end
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         level_r    <= {LVL_W{1'b0}};
         tx_ready_r <= 1'b1;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= tx_data;
            wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         level_r    <= level_nxt_s;
         tx_ready_r <= (level_nxt_s != LVL_FULL);
      end
   end

   assign tx_ready   = tx_ready_r;
   assign fifo_level = level_r;
   assign rx_data    = rx_data_r;
   assign rx_valid   = rx_valid_r;
   assign underrun   = underrun_r;
   assign ssp_clk    = ssp_clk_r;
   assign ssp_frame  = ssp_frame_r;
   assign ssp_din    = ssp_din_r;

endmodule

// File: tb/tb_hi_ssp_framer.sv
// Testbench for hi_ssp_framer (WORD_W=8, CLK_DIV=4, FIFO_DEPTH=4).
// A reference model derived from the link timing rules runs every cycle;
// directed sequences and a table add spec-constant checks on top.
module tb_hi_ssp_framer;

   localparam int W     = 8;
   localparam int D     = 4;
   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [2:0] fifo_level;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       underrun;
   logic       ssp_clk;
   logic       ssp_frame;
   logic       ssp_din;
   logic       ssp_dout;

   int checks   = 0;
   int failures = 0;

   hi_ssp_framer #(.WORD_W(W), .CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
      .ck_1356meg (clk),
      .rst_n      (rst_n),
      .en         (en),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .fifo_level (fifo_level),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .underrun   (underrun),
      .ssp_clk    (ssp_clk),
      .ssp_frame  (ssp_frame),
      .ssp_din    (ssp_din),
      .ssp_dout   (ssp_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_q[$];
   bit         m_run = 1'b0;
   int         m_n = 0;
   logic [7:0] m_word = 8'h00;
   bit         dout_hist[$];
   logic       exp_clk = 1'b0, exp_frame = 1'b0, exp_din = 1'b0;
   logic       exp_rxv = 1'b0, exp_und = 1'b0, exp_rdy = 1'b1;
   logic [2:0] exp_lvl = 3'd0;
   logic [7:0] exp_rxd = 8'h00;

   task automatic model_step();
      bit ready_pre;
      int m, r, pos, val;
      exp_rxv = 1'b0;
      exp_und = 1'b0;
      if (!rst_n) begin
         m_q.delete();
         m_run = 1'b0;
         exp_clk = 1'b0; exp_frame = 1'b0; exp_din = 1'b0;
         exp_rxd = 8'h00; exp_lvl = 3'd0; exp_rdy = 1'b1;
         return;
      end
      ready_pre = (m_q.size() < DEPTH);
      if (!en) begin
         m_run = 1'b0;
         exp_clk = 1'b0; exp_frame = 1'b0; exp_din = 1'b0;
      end else begin
         if (!m_run) begin
            m_run = 1'b1;
            m_n = 0;
            dout_hist.delete();
         end else begin
            m_n++;
         end
         if (m_n < D) begin
            exp_clk = 1'b0; exp_frame = 1'b0; exp_din = 1'b0;
         end else begin
            m   = m_n - D;
            r   = m / (2 * D);
            pos = r % W;
            exp_clk = ((m / D) % 2) == 0;
            if (m % (2 * D) == 0) begin
               dout_hist.push_back(ssp_dout);
               if (pos == 0) begin
                  if (m_q.size() > 0) m_word = m_q.pop_front();
                  else begin
                     m_word = 8'h00;
                     exp_und = 1'b1;
                  end
                  if (r >= W) begin
                     val = 0;
                     for (int i = 0; i < W; i++) val = val * 2 + int'(dout_hist[r - W + 1 + i]);
                     exp_rxd = val[7:0];
                     exp_rxv = 1'b1;
                  end
               end
            end
            exp_frame = (pos == 0);
            exp_din   = m_word[W - 1 - pos];
         end
      end
      if (tx_valid && ready_pre) m_q.push_back(tx_data);
      exp_lvl = 3'(m_q.size());
      exp_rdy = (m_q.size() < DEPTH);
   endtask

   // ---------------- monitor: model + per-cycle compare + observations ----
   bit   obs_prev_clk = 1'b0;
   int   cyc_cnt = 0;
   bit   obs_din_q[$];
   int   obs_rise_t[$];
   logic [7:0] obs_rx_q[$];
   int   obs_underruns = 0;
   int   obs_din_ones = 0;
   int   obs_frame_cyc = 0;

   always @(posedge clk) begin
      model_step();
      #1;
      chk("ssp_clk",    32'(ssp_clk),    32'(exp_clk));
      chk("ssp_frame",  32'(ssp_frame),  32'(exp_frame));
      chk("ssp_din",    32'(ssp_din),    32'(exp_din));
      chk("rx_valid",   32'(rx_valid),   32'(exp_rxv));
      chk("rx_data",    32'(rx_data),    32'(exp_rxd));
      chk("underrun",   32'(underrun),   32'(exp_und));
      chk("fifo_level", 32'(fifo_level), 32'(exp_lvl));
      chk("tx_ready",   32'(tx_ready),   32'(exp_rdy));
      cyc_cnt++;
      if (ssp_clk && !obs_prev_clk) begin
         obs_din_q.push_back(ssp_din);
         obs_rise_t.push_back(cyc_cnt);
      end
      obs_prev_clk = ssp_clk;
      if (rx_valid) obs_rx_q.push_back(rx_data);
      if (underrun) obs_underruns++;
      if (ssp_din) obs_din_ones++;
      if (ssp_frame) obs_frame_cyc++;
   end

   // ---------------- ARM side: drives ssp_dout at ssp_clk falling edges ----
   logic [63:0] arm_bits = 64'd0;
   int          arm_len  = 0;
   bit          arm_rand = 1'b0;

   initial begin
      bit drv_prev;
      int drv_idx;
      ssp_dout = 1'b0;
      drv_prev = 1'b0;
      drv_idx  = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!en) begin
            drv_idx = 0;
         end else if (drv_prev && !ssp_clk) begin
            if (drv_idx < arm_len) ssp_dout = arm_bits[arm_len - 1 - drv_idx];
            else if (arm_rand) ssp_dout = 1'($urandom_range(0, 1));
            else ssp_dout = 1'b0;
            drv_idx++;
         end
         drv_prev = ssp_clk;
      end
   end

   // ---------------- directed and random stimulus ----------------
   typedef struct {
      logic       v;
      logic [7:0] d;
      logic [2:0] lvl;
      logic       rdy;
   } fifo_vec_t;

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".ssp_clk"},    32'(ssp_clk),    32'd0);
      chk({tag, ".ssp_frame"},  32'(ssp_frame),  32'd0);
      chk({tag, ".ssp_din"},    32'(ssp_din),    32'd0);
      chk({tag, ".rx_valid"},   32'(rx_valid),   32'd0);
      chk({tag, ".underrun"},   32'(underrun),   32'd0);
      chk({tag, ".rx_data"},    32'(rx_data),    32'd0);
      chk({tag, ".fifo_level"}, 32'(fifo_level), 32'd0);
      chk({tag, ".tx_ready"},   32'(tx_ready),   32'd1);
   endtask

   task automatic push_word(input logic [7:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      cyc(1);
      tx_valid = 1'b0;
   endtask

   initial begin
      fifo_vec_t   fv[6];
      logic [15:0] exp_bits;
      logic [7:0]  exp_words[5];
      logic [7:0]  w;
      int          base, ubase, rbase, obase, fbase, lat;

      fv[0] = '{1'b1, 8'h01, 3'd1, 1'b1};
      fv[1] = '{1'b1, 8'h02, 3'd2, 1'b1};
      fv[2] = '{1'b1, 8'h03, 3'd3, 1'b1};
      fv[3] = '{1'b1, 8'h04, 3'd4, 1'b0};
      fv[4] = '{1'b1, 8'h05, 3'd4, 1'b0};
      fv[5] = '{1'b0, 8'h00, 3'd4, 1'b0};
      exp_bits     = 16'h1DAA;
      exp_words[0] = 8'h01; exp_words[1] = 8'h02; exp_words[2] = 8'h03;
      exp_words[3] = 8'h04; exp_words[4] = 8'h00;

      rst_n = 1'b0; en = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      cyc(2);
      chk_reset_outputs("reset_hold");
      rst_n = 1'b1;
      cyc(1);

      // TX framing + RX loopback
      push_word(8'h1D);
      push_word(8'hAA);
      arm_bits = 64'h0000_0000_0000_B500; arm_len = 16; arm_rand = 1'b0;
      base = obs_din_q.size(); ubase = obs_underruns; rbase = obs_rx_q.size();
      fbase = obs_frame_cyc; obase = obs_rise_t.size();
      en = 1'b1;
      cyc(130);
      chk("framing.no_underrun_first_two", 32'(obs_underruns - ubase), 32'd0);
      cyc(10);
      for (int i = 0; i < 16; i++)
         chk($sformatf("framing.din_bit%0d", i), 32'(obs_din_q[base + i]), 32'(exp_bits[15 - i]));
      chk("framing.clk_period0", 32'(obs_rise_t[obase + 1] - obs_rise_t[obase]), 32'd8);
      chk("framing.clk_period1", 32'(obs_rise_t[obase + 2] - obs_rise_t[obase + 1]), 32'd8);
      chk("framing.frame_cycles", 32'(obs_frame_cyc - fbase), 32'd24);
      chk("framing.third_word_underrun", 32'(obs_underruns - ubase), 32'd1);
      chk("loopback.rx_count", 32'(obs_rx_q.size() - rbase), 32'd2);
      chk("loopback.rx_word0", 32'(obs_rx_q[rbase]), 32'hB5);
      chk("loopback.rx_word1", 32'(obs_rx_q[rbase + 1]), 32'h00);
      en = 1'b0;
      cyc(2);
      arm_len = 0;

      // Underrun with empty FIFO for three words
      ubase = obs_underruns; base = obs_din_ones;
      en = 1'b1;
      cyc(190);
      chk("underrun.count", 32'(obs_underruns - ubase), 32'd3);
      chk("underrun.din_ones", 32'(obs_din_ones - base), 32'd0);
      en = 1'b0;
      cyc(2);

      // FIFO full (table-driven), then drain
      for (int i = 0; i < 6; i++) begin
         tx_valid = fv[i].v;
         tx_data  = fv[i].d;
         cyc(1);
         chk($sformatf("fifo_full.level%0d", i), 32'(fifo_level), 32'(fv[i].lvl));
         chk($sformatf("fifo_full.ready%0d", i), 32'(tx_ready), 32'(fv[i].rdy));
      end
      tx_valid = 1'b0;
      base = obs_din_q.size(); ubase = obs_underruns;
      en = 1'b1;
      cyc(320);
      for (int k = 0; k < 5; k++) begin
         w = 8'h00;
         for (int i = 0; i < 8; i++) w = {w[6:0], 1'(obs_din_q[base + 8 * k + i])};
         chk($sformatf("fifo_full.word%0d", k), 32'(w), 32'(exp_words[k]));
      end
      chk("fifo_full.underruns", 32'(obs_underruns - ubase), 32'd1);
      en = 1'b0;
      cyc(2);

      // Abort after three bits, then re-enable
      push_word(8'h3C);
      push_word(8'h5A);
      rbase = obs_rx_q.size();
      en = 1'b1;
      cyc(22);
      en = 1'b0;
      cyc(1);
      chk("abort.ssp_clk", 32'(ssp_clk), 32'd0);
      chk("abort.ssp_frame", 32'(ssp_frame), 32'd0);
      chk("abort.ssp_din", 32'(ssp_din), 32'd0);
      chk("abort.no_rx_valid", 32'(obs_rx_q.size() - rbase), 32'd0);
      base = obs_din_q.size();
      en = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         cyc(1);
         if (ssp_frame && lat == 0) lat = k;
      end
      chk("abort.frame_latency", 32'(lat), 32'(D + 1));
      cyc(70);
      w = 8'h00;
      for (int i = 0; i < 8; i++) w = {w[6:0], 1'(obs_din_q[base + i])};
      chk("abort.next_word", 32'(w), 32'h5A);
      en = 1'b0;
      cyc(2);

      // Asynchronous reset mid-word with FIFO level 3
      push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
      en = 1'b1;
      cyc(30);
      chk("reset_mid.level_before", 32'(fifo_level), 32'd3);
      #3 rst_n = 1'b0;
      #1 chk_reset_outputs("reset_mid");
      @(negedge clk);
      en = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      chk("reset_rel.fifo_level", 32'(fifo_level), 32'd0);
      chk("reset_rel.tx_ready", 32'(tx_ready), 32'd1);

      // Randomized traffic against the model
      arm_rand = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) en = ~en;
         tx_valid = ($urandom_range(0, 47) == 0);
         tx_data  = 8'($urandom);
         cyc(1);
      end
      tx_valid = 1'b0;
      en = 1'b0;
      cyc(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hi_ssp_framer.md
# hi_ssp_framer

Parametrised SSP link engine between the FPGA mode blocks and the ARM. It generates `ssp_clk` and `ssp_frame` and serialises buffered words onto `ssp_din`, MSB first. In the same frames it deserialises ARM words from `ssp_dout`. It replaces the fixed 8-bit ad-hoc framing in the hi_* modes with configurable word width, clock divider and TX FIFO depth, and adds underrun reporting and enable/abort behaviour.

## Interface
Parameters:
- `WORD_W`, 8: bits per SSP frame (≥2).
- `CLK_DIV`, 4: `ck_1356meg` cycles per `ssp_clk` half-period (≥2).
- `FIFO_DEPTH`, 4: TX FIFO entries (power of 2, ≥2).

Ports:
- `ck_1356meg` in 1: sole clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: link enable.
- `tx_data` in WORD_W: word to send to the ARM.
- `tx_valid` in 1: `tx_data` offered.
- `tx_ready` out 1: FIFO not full.
- `fifo_level` out $clog2(FIFO_DEPTH+1): current occupancy.
- `rx_data` out WORD_W: last complete word received from the ARM.
- `rx_valid` out 1: one-cycle pulse, `rx_data` updated.
- `underrun` out 1: one-cycle pulse, zero word loaded because the FIFO was empty.
- `ssp_clk` out 1, `ssp_frame` out 1, `ssp_din` out 1: to ARM.
- `ssp_dout` in 1: from ARM.

## Operation
- **Divider:** counter 0..CLK_DIV-1 runs while `en`=1. A tick occurs at count CLK_DIV-1, and `ssp_clk` toggles on each tick.
  - Rise tick: a tick with `ssp_clk`=0.
  - Fall tick: a tick with `ssp_clk`=1.
- **Bit counter:** counts WORD_W-1 down to 0 and advances on each rise tick. On wrap it reloads WORD_W-1, so words run back-to-back with no gap.
- **Word start** (rise tick with bit counter = WORD_W-1):
  - If `fifo_level`>0: pop the FIFO head into the TX shift register.
  - Otherwise: load all zeros and pulse `underrun` for one cycle.
  - In both cases, drive the MSB onto `ssp_din` and set `ssp_frame`=1.
- **Following rise ticks:** shift the next bit onto `ssp_din`. `ssp_frame` returns to 0 on the rise tick after the one that set it, so it is high for exactly one `ssp_clk` period (2*CLK_DIV cycles).
- **RX sampling:** each rise tick samples `ssp_dout` (the pre-edge value, which the ARM drove at the preceding falling edge) into the RX shift register, MSB first.
  - A word is the WORD_W samples taken at rise ticks 1..WORD_W after a word-start tick.
  - Sample WORD_W coincides with the next word start. In that cycle `rx_data` is loaded and `rx_valid` pulses.
  - The sample taken at the very first word start after enable is discarded.
- **FIFO:**
  - Push when `tx_valid`&&`tx_ready`.
  - `tx_ready` = !full, decoded from registered occupancy.
  - Push and pop in the same cycle: the level is unchanged.
  - When full, `tx_ready`=0 even in a pop cycle, and the offered word is not accepted.
  - When empty, a simultaneous push and word start yields a zero word plus `underrun`; the pushed word is sent in the next frame.
- **`en`=0:**
  - Divider and bit counter return to their initial state.
  - `ssp_clk`, `ssp_frame` and `ssp_din` are driven 0 in the cycle after `en` is sampled low.
  - A partial RX word is discarded with no `rx_valid`.
  - A partial TX word is lost; it is not re-queued.
  - FIFO contents and pushes are retained.
- **Reset:** asynchronous, clears everything including the FIFO.

## Timing
- All outputs are registered. Reset values:
  - `ssp_clk`, `ssp_frame`, `ssp_din`, `rx_valid`, `underrun` = 0.
  - `rx_data` = 0, `fifo_level` = 0.
  - `tx_ready` = 1 during and after reset.
- `en` sampled high at edge 0: first rise tick at edge CLK_DIV. `ssp_clk`, `ssp_frame` and the MSB are all high/valid after that edge.
- `ssp_clk` period is 2*CLK_DIV cycles, 50% duty. `ssp_din` and `ssp_frame` change only on rise-tick edges.
- `rx_valid` is in the same cycle as the word-start rise tick that captures the last bit, i.e. every WORD_W*2*CLK_DIV cycles in steady state.
- Push-to-`ssp_din` latency: at most one full word period plus CLK_DIV cycles when the FIFO is empty and the link is enabled.

## Test plan
- **Reset:** assert `rst_n`=0 mid-word with FIFO level 3. Required: all outputs take their reset values immediately; `fifo_level`=0 and `tx_ready`=1 after release.
- **TX framing** (WORD_W=8, CLK_DIV=4): push 0x1D then 0xAA, then `en`=1. Required:
  - `ssp_clk` period 8 cycles.
  - `ssp_frame` high 8 cycles at each word start.
  - `ssp_din` on successive rise ticks is 0,0,0,1,1,1,0,1 then 1,0,1,0,1,0,1,0.
  - No `underrun` for the first two words.
- **RX loopback:** bench drives 0xB5 on `ssp_dout` MSB first, changing at `ssp_clk` falling edges, starting in the first word period. Required: `rx_valid` pulses once at the second word start with `rx_data`=0xB5; the next word 0x00 gives `rx_data`=0x00.
- **Underrun:** `en`=1 with an empty FIFO for 3 words. Required: `ssp_din`=0 throughout and `underrun` pulses exactly 3 times, once per word start.
- **FIFO full:** with `en`=0, offer 5 words 0x01..0x05 back-to-back. Required: `fifo_level`=4 and `tx_ready`=0 after the 4th; 0x05 is not accepted. After `en`=1, the words sent are 0x01, 0x02, 0x03, 0x04, then zero with `underrun`.
- **Abort:** drop `en` after 3 bits of a word. Required: `ssp_clk`, `ssp_frame` and `ssp_din` are 0 the next cycle and no `rx_valid`. Re-enable: new frame after CLK_DIV cycles carrying the next FIFO word; the aborted word is not resent.
